wptr_full_ctrl: RTL and testbench

//  Write-side pointer and full-flag controller of the dual-clock event FIFO, in the wclk domain.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/gray_to_bin.sv | 14 +
 rtl/wptr_full_ctrl.sv | 120 ++++++++++++
 tb/tb_wptr_full_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock event FIFO: default address width,
// pointer type and the binary-to-Gray helper used by both pointer domains.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 3;

    typedef logic [FIFO_ADDR_W:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Parameterised Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray_to_bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[W-1:i];
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer / full-flag controller of the dual-clock event FIFO (wclk domain).
// Optional registered almost_full output is enabled with `define FIFO_ALMOST_FULL_EN.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = FIFO_ADDR_W,
`ifdef FIFO_ALMOST_FULL_EN
    parameter int AF_MARGIN = 2,
`endif
    parameter int OVF_W     = 4
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              winc,
    input  logic [ADDR_W:0]   wq2_rptr,
    input  logic              clr_ovf,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr,
    output logic              wfull,
    output logic              ovf_flag,
    output logic [OVF_W-1:0]  ovf_cnt
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic              almost_full
`endif
);

    localparam logic [OVF_W-1:0] OVF_MAX = '1;
    localparam logic [OVF_W-1:0] OVF_ONE = OVF_W'(1);

    logic [ADDR_W:0]  r_wbin;
    logic [ADDR_W:0]  r_wptr;
    logic             r_wfull;
    logic             r_ovf_flag;
    logic [OVF_W-1:0] r_ovf_cnt;

    logic             w_wen;
    logic             w_drop;
    logic [ADDR_W:0]  w_wbin_next;
    logic [ADDR_W:0]  w_wgray_next;
    logic [ADDR_W:0]  w_rptr_wrapped;
    logic             w_full_next;

    assign w_wen        = winc & ~r_wfull;
    assign w_drop       = winc &  r_wfull;
    assign w_wbin_next  = r_wbin + (ADDR_W+1)'(w_wen);
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // Full when the write pointer is one lap ahead: in Gray code that is the
    // read pointer with its two MSBs inverted.
    assign w_rptr_wrapped = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
    assign w_full_next    = (w_wgray_next == w_rptr_wrapped);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin  <= '0;
            r_wptr  <= '0;
            r_wfull <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wptr  <= w_wgray_next;
            r_wfull <= w_full_next;
        end
    end

    // Clear wins over history, but a drop in the same cycle still counts once.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_ovf_flag <= 1'b0;
            r_ovf_cnt  <= '0;
        end else if (clr_ovf) begin
            r_ovf_flag <= w_drop;
            r_ovf_cnt  <= w_drop ? OVF_ONE : '0;
        end else if (w_drop) begin
            r_ovf_flag <= 1'b1;
            if (r_ovf_cnt != OVF_MAX) begin
                r_ovf_cnt <= r_ovf_cnt + OVF_ONE;
            end
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W+1)'((1 << ADDR_W) - AF_MARGIN);

    logic [ADDR_W:0] w_rbin;
    logic [ADDR_W:0] w_level_next;
    logic            r_almost_full;

    gray_to_bin #(
        .W (ADDR_W + 1)
    ) u_gray_to_bin (
        .i_gray (wq2_rptr),
        .o_bin  (w_rbin)
    );

    // Modulo subtraction gives the occupancy directly, across pointer wrap.
    assign w_level_next = w_wbin_next - w_rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_level_next >= AF_LEVEL);
        end
    end

    assign almost_full = r_almost_full;
`endif

    assign wen      = w_wen;
    assign waddr    = r_wbin[ADDR_W-1:0];
    assign wptr     = r_wptr;
    assign wfull    = r_wfull;
    assign ovf_flag = r_ovf_flag;
    assign ovf_cnt  = r_ovf_cnt;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed, table-driven bench for wptr_full_ctrl (ADDR_W=3, OVF_W=4); the
// almost_full sequence runs only when FIFO_ALMOST_FULL_EN is defined.
module tb_wptr_full_ctrl;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [3:0] wq2_rptr;
    logic       clr_ovf;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull;
    logic       ovf_flag;
    logic [3:0] ovf_cnt;
`ifdef FIFO_ALMOST_FULL_EN
    logic       almost_full;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    wptr_full_ctrl #(
        .ADDR_W (3),
        .OVF_W  (4)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .winc        (winc),
        .wq2_rptr    (wq2_rptr),
        .clr_ovf     (clr_ovf),
        .wen         (wen),
        .waddr       (waddr),
        .wptr        (wptr),
        .wfull       (wfull),
        .ovf_flag    (ovf_flag),
        .ovf_cnt     (ovf_cnt)
`ifdef FIFO_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic       winc;
        logic [3:0] rptr;
        logic       clr;
        logic       exp_wen;    // before the edge
        logic [2:0] exp_waddr;  // before the edge
        logic [3:0] exp_wptr;   // after the edge
        logic       exp_wfull;
        logic       exp_flag;
        logic [3:0] exp_cnt;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1: drive, check combinational outputs, clock, check registers.
    task automatic apply(input vec_t v, input string tag);
        winc     = v.winc;
        wq2_rptr = v.rptr;
        clr_ovf  = v.clr;
        #1;
        check({tag, ".wen"},   32'(wen),   32'(v.exp_wen));
        check({tag, ".waddr"}, 32'(waddr), 32'(v.exp_waddr));
        @(posedge wclk);
        #1;
        check({tag, ".wptr"},     32'(wptr),     32'(v.exp_wptr));
        check({tag, ".wfull"},    32'(wfull),    32'(v.exp_wfull));
        check({tag, ".ovf_flag"}, 32'(ovf_flag), 32'(v.exp_flag));
        check({tag, ".ovf_cnt"},  32'(ovf_cnt),  32'(v.exp_cnt));
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, ".wptr"},     32'(wptr),     0);
        check({tag, ".waddr"},    32'(waddr),    0);
        check({tag, ".wfull"},    32'(wfull),    0);
        check({tag, ".ovf_flag"}, 32'(ovf_flag), 0);
        check({tag, ".ovf_cnt"},  32'(ovf_cnt),  0);
`ifdef FIFO_ALMOST_FULL_EN
        check({tag, ".almost_full"}, 32'(almost_full), 0);
`endif
    endtask

    task automatic release_reset();
        winc    = 1'b0;
        clr_ovf = 1'b0;
        wrst_n  = 1'b1;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        vec_t v;

        // Fill: 8 writes into empty FIFO, then drops, clears, read-side release.
        vecs[0]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd0, 4'h1, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd1, 4'h3, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd2, 4'h2, 1'b0, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd3, 4'h6, 1'b0, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd4, 4'h7, 1'b0, 1'b0, 4'd0};
        vecs[5]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd5, 4'h5, 1'b0, 1'b0, 4'd0};
        vecs[6]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd6, 4'h4, 1'b0, 1'b0, 4'd0};
        vecs[7]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd7, 4'hC, 1'b1, 1'b0, 4'd0};
        vecs[8]  = '{1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd1};
        vecs[9]  = '{1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd2};
        vecs[10] = '{1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd3};
        vecs[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 4'hC, 1'b1, 1'b0, 4'd0};
        vecs[12] = '{1'b1, 4'h0, 1'b1, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd1};
        vecs[13] = '{1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 4'hC, 1'b1, 1'b0, 4'd0};
        vecs[14] = '{1'b0, 4'h1, 1'b0, 1'b0, 3'd0, 4'hC, 1'b0, 1'b0, 4'd0};
        vecs[15] = '{1'b1, 4'h1, 1'b0, 1'b1, 3'd0, 4'hD, 1'b1, 1'b0, 4'd0};

        // Reset held with winc=1: nothing may move.
        wrst_n   = 1'b0;
        winc     = 1'b1;
        wq2_rptr = 4'h0;
        clr_ovf  = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        check_regs_zero("reset_hold");
        release_reset();
        check_regs_zero("reset_release");

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // 17 drops while full (rbin=1, wbin=9): counter saturates at 15.
        for (int i = 0; i < 17; i++) begin
            v = '{1'b1, 4'h1, 1'b0, 1'b0, 3'd1, 4'hD, 1'b1, 1'b1, 4'((i + 1 > 15) ? 15 : i + 1)};
            apply(v, $sformatf("sat%0d", i));
        end

        // Asynchronous reset mid-cycle clears state before the next edge.
        winc = 1'b1;
        #3;
        wrst_n = 1'b0;
        #1;
        check_regs_zero("async_reset");
        @(posedge wclk);
        #1;
        release_reset();

        // 20 writes with the read pointer trailing 2 behind: wraps, never full.
        for (int i = 0; i < 20; i++) begin
            logic [3:0] rb;
            rb = (i < 2) ? 4'd0 : 4'(i - 2);
            v  = '{1'b1, gray(rb), 1'b0, 1'b1, 3'(i % 8), gray(4'((i + 1) % 16)), 1'b0, 1'b0, 4'd0};
            apply(v, $sformatf("wrap%0d", i));
        end

`ifdef FIFO_ALMOST_FULL_EN
        wrst_n = 1'b0;
        #1;
        release_reset();
        check_regs_zero("af_reset");
        for (int i = 0; i < 6; i++) begin
            v = '{1'b1, 4'h0, 1'b0, 1'b1, 3'(i), gray(4'(i + 1)), 1'b0, 1'b0, 4'd0};
            apply(v, $sformatf("af%0d", i));
            check($sformatf("af%0d.almost_full", i), 32'(almost_full), 32'(i + 1 >= 6));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
